// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion (FIPS-197). The key length is chosen per request.
// One 32-bit word is produced per cycle through a single 4-byte S-box bank.
// The schedule is stored internally and read back through a registered round-key port.
// Optional build macro KEYSCHED_INV_EN: when rk_inv=1, inner round keys are returned
// in equivalent-inverse-cipher form, with InvMixColumns applied to each word.
module aes_key_schedule #(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [32*MAX_NK-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           nr,
  input  logic [3:0]           rk_sel,
  input  logic                 rk_inv,
  output logic [127:0]         rk_out
);
  localparam int DEPTH = 4 * (MAX_NK + 7);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t               state_q, state_d;
  logic [32*MAX_NK-1:0] key_q, key_d;
  logic [3:0]           nk_q, nk_d;
  logic [3:0]           nr_lat_q, nr_lat_d;
  logic [3:0]           nr_q, nr_d;
  logic [5:0]           i_q, i_d;
  logic [3:0]           j_q, j_d;
  logic [7:0]           rcon_q, rcon_d;
  logic                 err_q, err_d;
  logic [127:0]         rk_out_q, rk_out_d;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          w_prev, w_back, sub_in, sub_out, temp, w_new;
  logic [3:0]           nk_req;
  logic                 req_ok;
  logic [5:0]           rd_base;
  logic [127:0]         rk_fwd;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as the GF(2^8) inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

`ifdef KEYSCHED_INV_EN
  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
`else
  logic unused_rk_inv;
  assign unused_rk_inv = rk_inv;
`endif

  // Decode the requested key length and decide whether this build supports it
  always_comb begin
    case (key_len)
      2'b00:   nk_req = 4'd4;
      2'b01:   nk_req = 4'd6;
      2'b10:   nk_req = 4'd8;
      default: nk_req = 4'd0;
    endcase
    req_ok = (key_len != 2'b11) && (int'(nk_req) <= MAX_NK);
  end

  // Compute the next schedule word; j_q tracks i mod Nk so no divider is needed
  always_comb begin
    w_prev  = mem[i_q - 6'd1];
    w_back  = mem[i_q - 6'(nk_q)];
    sub_in  = (j_q == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    if (j_q == 4'd0)                         temp = sub_out ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && j_q == 4'd4)    temp = sub_out;
    else                                     temp = w_prev;
    w_new = w_back ^ temp;
  end

  // Next-state logic for the expansion FSM and its counters
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    nk_d     = nk_q;
    nr_lat_d = nr_lat_q;
    nr_d     = nr_q;
    i_d      = i_q;
    j_d      = j_q;
    rcon_d   = rcon_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (req_ok) begin
            state_d  = LOAD;
            key_d    = key;
            nk_d     = nk_req;
            nr_lat_d = nk_req + 4'd6;
            err_d    = 1'b0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        i_d     = 6'(nk_q);
        j_d     = 4'd0;
        rcon_d  = 8'h01;
        state_d = EXPAND;
      end
      EXPAND: begin
        i_d = i_q + 6'd1;
        j_d = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
        if (j_q == 4'd0) rcon_d = xtime(rcon_q);
        if (i_q == {nr_lat_q, 2'b11}) begin
          state_d = DONE;
          nr_d    = nr_lat_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-key read mux; only a completed schedule is visible
  always_comb begin
    rk_fwd   = '0;
    rk_out_d = '0;
    rd_base  = {rk_sel, 2'b00};
    if (state_q == DONE && rk_sel <= nr_q) begin
      rk_fwd   = {mem[rd_base], mem[rd_base + 6'd1], mem[rd_base + 6'd2], mem[rd_base + 6'd3]};
      rk_out_d = rk_fwd;
`ifdef KEYSCHED_INV_EN
      if (rk_inv && rk_sel != 4'd0 && rk_sel < nr_q)
        rk_out_d = {inv_mix_word(rk_fwd[127:96]), inv_mix_word(rk_fwd[95:64]),
                    inv_mix_word(rk_fwd[63:32]),  inv_mix_word(rk_fwd[31:0])};
`endif
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      nk_q     <= 4'd0;
      nr_lat_q <= 4'd0;
      nr_q     <= 4'd0;
      i_q      <= 6'd0;
      j_q      <= 4'd0;
      rcon_q   <= 8'h00;
      err_q    <= 1'b0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      nk_q     <= nk_d;
      nr_lat_q <= nr_lat_d;
      nr_q     <= nr_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      err_q    <= err_d;
      rk_out_q <= rk_out_d;
    end
  end

  // Key capture register; holds data only, so it needs no reset
  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  // Schedule storage: key words written in LOAD, one derived word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (4'(k) < nk_q) mem[k] <= key_q[32*(MAX_NK-k)-1 -: 32];
      end
    end else if (state_q == EXPAND) begin
      mem[i_q] <= w_new;
    end
  end

  assign busy   = (state_q == LOAD) || (state_q == EXPAND);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign nr     = nr_q;
  assign rk_out = rk_out_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed testbench for aes_key_schedule using FIPS-197 key-expansion vectors.
// Honours KEYSCHED_INV_EN: when it is defined, the inverse-key read is checked
// against a local InvMixColumns model.
`timescale 1ns/1ps
module tb_aes_key_schedule;
  localparam int MAX_NK = 8;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hffff00005555aaaa};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [1:0]           key_len;
  logic [32*MAX_NK-1:0] key;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [3:0]           nr;
  logic [3:0]           rk_sel;
  logic                 rk_inv;
  logic [127:0]         rk_out;
  logic [127:0]         expInv;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_NK(MAX_NK)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_len (key_len),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .nr      (nr),
    .rk_sel  (rk_sel),
    .rk_inv  (rk_inv),
    .rk_out  (rk_out)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] invMixWord(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int c = 0; c < 4; c++) begin
      logic [7:0] x2, x4, x8;
      a[c]   = w[31-8*c -: 8];
      x2     = xt(a[c]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[c]  = x8 ^ a[c];
      m11[c] = x8 ^ x2 ^ a[c];
      m13[c] = x8 ^ x4 ^ a[c];
      m14[c] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic readKey(input string tag, input logic [3:0] sel, input logic inv,
                         input logic [127:0] expected);
    rk_sel = sel;
    rk_inv = inv;
    tick;
    checkOutput(tag, rk_out, expected);
  endtask

  // Start an expansion, optionally pulse start again while busy, and measure latency
  task automatic applyStimulus(input string tag, input logic [1:0] len,
                               input logic [255:0] k, input int expEdges,
                               input int pulseAt);
    int n;
    key_len = len;
    key     = k;
    rk_sel  = 4'd0;
    rk_inv  = 1'b0;
    start   = 1'b1;
    tick;
    start = 1'b0;
    checkOutput({tag, " busy after accept"}, 128'(busy), 128'd1);
    checkOutput({tag, " done after accept"}, 128'(done), 128'd0);
    n = 0;
    while (!done && n < 200) begin
      if (n == pulseAt) begin
        start   = 1'b1;
        key_len = 2'b10;
      end
      tick;
      n++;
      start   = 1'b0;
      key_len = len;
      if (n == 5) checkOutput({tag, " read during expand"}, rk_out, 128'd0);
    end
    checkOutput({tag, " latency"}, 128'(n), 128'(expEdges));
  endtask

  initial begin
    $display("[TB] starting aes_key_schedule bench");
    rst     = 1'b1;
    start   = 1'b1;
    key_len = 2'b00;
    key     = K128;
    rk_sel  = 4'd0;
    rk_inv  = 1'b0;
    tick;
    tick;
    checkOutput("reset busy", 128'(busy), 128'd0);
    checkOutput("reset done", 128'(done), 128'd0);
    checkOutput("reset err", 128'(err), 128'd0);
    checkOutput("reset nr", 128'(nr), 128'd0);
    checkOutput("reset rk_out", rk_out, 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick;

    // AES-128
    applyStimulus("aes128", 2'b00, K128, 41, -1);
    checkOutput("aes128 nr", 128'(nr), 128'd10);
    readKey("aes128 rk10", 4'd10, 1'b0, R128_10);
    readKey("aes128 rk1", 4'd1, 1'b0, R128_1);

    // AES-192
    applyStimulus("aes192", 2'b01, K192, 47, -1);
    checkOutput("aes192 nr", 128'(nr), 128'd12);
    readKey("aes192 rk12", 4'd12, 1'b0, R192_12);

    // AES-256
    applyStimulus("aes256", 2'b10, K256, 53, -1);
    checkOutput("aes256 nr", 128'(nr), 128'd14);
    readKey("aes256 rk14", 4'd14, 1'b0, R256_14);
    readKey("aes256 rk0", 4'd0, 1'b0, R256_0);
    readKey("aes256 rk15", 4'd15, 1'b0, 128'd0);

    // Illegal key length, then a valid request clears err
    key_len = 2'b11;
    start   = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("illegal err", 128'(err), 128'd1);
    checkOutput("illegal busy", 128'(busy), 128'd0);
    checkOutput("illegal done", 128'(done), 128'd0);
    readKey("illegal rk14", 4'd14, 1'b0, 128'd0);
    applyStimulus("after illegal", 2'b00, K128, 41, -1);
    checkOutput("after illegal err", 128'(err), 128'd0);

    // Reset with start at cycle 20 of an AES-256 run
    key_len = 2'b10;
    key     = K256;
    start   = 1'b1;
    tick;
    start = 1'b0;
    repeat (19) tick;
    rst   = 1'b1;
    start = 1'b1;
    tick;
    checkOutput("abort busy", 128'(busy), 128'd0);
    checkOutput("abort done", 128'(done), 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick;
    tick;
    checkOutput("abort stays idle", 128'(busy), 128'd0);
    readKey("abort rk0", 4'd0, 1'b0, 128'd0);
    applyStimulus("restart128", 2'b00, K128, 41, 10);
    checkOutput("restart nr", 128'(nr), 128'd10);
    readKey("restart rk10", 4'd10, 1'b0, R128_10);
    readKey("restart rk1", 4'd1, 1'b0, R128_1);

    // Inverse-cipher form of the AES-128 round keys
`ifdef KEYSCHED_INV_EN
    expInv = {invMixWord(R128_1[127:96]), invMixWord(R128_1[95:64]),
              invMixWord(R128_1[63:32]),  invMixWord(R128_1[31:0])};
`else
    expInv = R128_1;
`endif
    readKey("inv rk1", 4'd1, 1'b1, expInv);
    readKey("inv rk10", 4'd10, 1'b1, R128_10);
    readKey("inv rk0", 4'd0, 1'b1, K128[255:128]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Parametrised AES key expansion covering AES-128/192/256 (FIPS-197), selected at run time per request.
Generates the expanded schedule one 32-bit word per cycle through a single 4-byte S-box bank, and stores it internally.
Exposes the schedule through an indexed, registered round-key read port rather than a flat bus.
Sits between the key-load interface and the cipher/inverse-cipher round datapath.

Parameters:
MAX_NK, 8, largest supported key length in 32-bit words (legal: 4, 6, 8); sets key port width and storage depth 4*(MAX_NK+7) words.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset; overrides start
start  input  1  request expansion; accepted only when busy=0
key_len  input  2  00=128, 01=192, 10=256, 11=illegal; sampled with start
key  input  32*MAX_NK  cipher key, left-aligned; w0 = key[32*MAX_NK-1 -: 32]; unused low bits ignored
busy  output  1  expansion in progress
done  output  1  schedule valid for the last accepted key
err  output  1  last request rejected (illegal or unsupported key_len)
nr  output  4  round count of the stored schedule: 10/12/14
rk_sel  input  4  round-key index 0..14
rk_inv  input  1  request inverse-cipher form (see Optional Feature)
rk_out  output  128  round key rk_sel: words 4r..4r+3, w(4r) in the MSBs

Behaviour:
- Reset: the design uses one clock (clk); rst is synchronous and active-high. On reset, busy=0, done=0, err=0, nr=0, rk_out=0, and the FSM goes to IDLE. Reset wins over a same-cycle start. Storage RAM is not cleared.
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE/DONE plus start=1:
  - If key_len is 11, or Nk > MAX_NK: err=1, done=0, stay in/return to IDLE.
  - Otherwise: latch Nk (4/6/8) and Nr (Nk+6); clear err and done; busy=1; go to LOAD.
- LOAD (1 cycle): write w0..w(Nk-1). Set i=Nk, Rcon=01. Go to EXPAND.
- EXPAND: one word per cycle, with temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon,00,00,00}, then Rcon = xtime(Rcon) (sequence 01,02,04,…,80,1B,36).
  - Else if Nk=8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; i++.
  - The last word is i = 4*(Nr+1)-1, i.e. w43, w51 or w59.
- S-box is combinational, 4 instances; no extra cycle per SubWord.
- After writing the last word: go to DONE, with busy=0, done=1, nr=Nr registered the same edge.
- Latency: done rises exactly 4*(Nr+1)-Nk+1 clock edges after the accepting edge (41 / 47 / 53).
- start while busy=1 is ignored; there is no queueing.
- start in DONE restarts expansion; done falls on the edge after acceptance.
- Read port: rk_out is registered with 1-cycle latency from rk_sel/rk_inv.
  - rk_sel > nr, or done=0, gives rk_out=0.
  - Reads during EXPAND return 0.
- Reset mid-EXPAND aborts: IDLE, done=0. A later start performs a full fresh expansion.

Optional Feature:
KEYSCHED_INV_EN:
- Defined: with rk_inv=1 and 1 <= rk_sel <= nr-1, rk_out = InvMixColumns applied to each of the 4 words (equivalent inverse cipher keys). rk_sel=0 and rk_sel=nr are returned unmodified. The transform is combinational before the rk_out register, so latency stays at 1 cycle.
- Undefined: rk_inv is ignored and rk_out is always the forward key.

Test Plan:
1. AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done after exactly 41 edges; rk_sel=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_sel=1 gives a0fafe1788542cb123a339392a6c7605.
2. AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 edges, nr=12; rk_sel=12 gives e98ba06f448c773c8ecc720401002202.
3. AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 edges, nr=14; rk_sel=14 gives fe4890d1e6188d0b046df344706c631e; rk_sel=15 gives 0.
4. key_len=11 with start -> err=1, busy stays 0, done=0. A following valid AES-128 start clears err.
5. rst asserted at cycle 20 of an AES-256 run, together with start -> busy=0, done=0 and stays IDLE. Restarting AES-128 gives the vector-1 result in 41 edges. A start pulsed while busy is ignored.
6. With KEYSCHED_INV_EN, AES-128 vector-1 key, rk_inv=1, rk_sel=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6 (unmodified final round key). rk_sel=1 -> InvMixColumns of a0fafe17…, compared against the bench reference model.
